vec_wb_stage: RTL and testbench
===============================

# vec_wb_stage

Vector writeback stage directly downstream of the vector ALU. Each cycle it can accept one full-width vector result (VLEN elements of ELEN bits). It merges that result with the old destination contents under vector-length and mask control. The merged result is queued in a 2-entry FIFO and presented to the vector register file write port with a valid/ready handshake. This decouples ALU issue from register-file write-port availability.

## Interface
- VLEN, 64: number of elements per vector (same meaning as the ALU's VLEN).
- ELEN, 32: element width in bits.
- VLW, $clog2(VLEN)+1: width of the vl field.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all queued entries.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept a result this cycle.
- aluout  in  [ELEN-1:0] x [0:VLEN-1]  ALU result per element.
- vd_old  in  [ELEN-1:0] x [0:VLEN-1]  current destination register contents.
- vmask  in  VLEN  per-element mask bits (v0).
- vm  in  1  1 = unmasked op; 0 = masked by vmask.
- vl  in  VLW  active vector length.
- vd  in  5  destination register index.
- out_valid  out  1  write request valid.
- out_ready  in  1  register file accepts the write.
- wdata  out  [ELEN-1:0] x [0:VLEN-1]  merged write data.
- wvd  out  5  destination index of the head entry.
- wen_mask  out  VLEN  per-element write enables of the head entry.

## Operation
- Element i is active iff i < vl_eff and (vm or vmask[i]), where vl_eff = min(vl, VLEN).
- Merge is computed combinationally from the inputs and captured on push:
  - active element i: data[i] = aluout[i], en[i] = 1.
  - inactive element i: data[i] = vd_old[i], en[i] = 0.
- Each stored entry holds {data, en, vd}.
- FIFO: 2 entries, separate read and write pointers (1 bit each, wrapping 1 -> 0), and count 0..2.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !reset & (count < 2). in_ready does not depend on out_ready, so a full FIFO does not push even when a pop happens in the same cycle.
- out_valid = (count != 0). wdata, wvd and wen_mask always show the head entry, and show all-zero when count == 0.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together (count == 1): count stays 1; the new entry becomes head on the next cycle.
- flush: takes priority over push and pop. Pointers and count go to 0 next cycle. A push presented in the flush cycle is dropped; upstream sees in_ready but the data is discarded.
- vl = 0, or all elements masked: the entry is still queued, with en = 0 and data = vd_old. The register-file write becomes a no-op but keeps ordering.
- Pushed data is never modified while it is queued.

## Timing
- Reset, asynchronous: count = 0, pointers = 0. out_valid = 0, wdata = 0, wvd = 0, wen_mask = 0, in_ready = 0 while reset is high.
- On the first clock after reset deassertion: in_ready = 1.
- Latency: a result pushed at edge N appears at the head with out_valid = 1 after edge N, if the FIFO was empty. No combinational path from input data to output data.
- Throughput: 1 vector per cycle while out_ready is held high.
- Reset asserted mid-operation: all queued entries are lost immediately, with no partial write.
- While out_valid = 1 and out_ready = 0, the outputs hold stable.

## Test plan
- Unmasked full length: vm=1, vl=64, aluout[i]=i, vd_old[i]=32'hFFFF_FFFF, vd=3, out_ready=1 -> one cycle later out_valid=1, wdata[i]=i, wen_mask=all ones, wvd=3.
- Tail and mask: vm=0, vl=10, vmask=64'h5555…, aluout[i]=32'hA, vd_old[i]=32'hB -> even i<10 give wdata=A with en=1; all other elements give B with en=0.
- vl clamp and zero: vl=127 behaves like vl=64. vl=0 queues an entry with wen_mask=0 and wdata=vd_old.
- Backpressure: out_ready=0, push three vectors vd=1,2,3 back-to-back -> in_ready drops after 2 pushes and the third stalls. Then raise out_ready -> writes appear in order 1,2,3 with outputs stable while stalled.
- Simultaneous push/pop at count=1: count stays 1 and the head advances to the new entry next cycle. At count=2 with pop, in_ready=0 and no push occurs.
- Flush and reset: queue 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0 and count=0. Assert reset asynchronously mid-stall -> out_valid and wen_mask go to 0 immediately.

Source files
------------

// File: rtl/vec_wb_stage.sv
// Vector writeback stage: merges ALU results with the old destination under vl/mask
// control and queues them in a 2-entry FIFO in front of the register-file write port.
module vec_wb_stage #(
  parameter int VLEN = 64,
  parameter int ELEN = 32,
  parameter int VLW  = $clog2(VLEN) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [VLEN*ELEN-1:0] aluout,
  input  logic [VLEN*ELEN-1:0] vd_old,
  input  logic [VLEN-1:0]      vmask,
  input  logic                 vm,
  input  logic [VLW-1:0]       vl,
  input  logic [4:0]           vd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VLEN*ELEN-1:0] wdata,
  output logic [4:0]           wvd,
  output logic [VLEN-1:0]      wen_mask
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // in_ready never looks at out_ready, so a full queue refuses a push even while popping.
  // Element i lives in bits [i*ELEN +: ELEN] of every vector bus.

  localparam logic [VLW-1:0] VLEN_W = VLW'(VLEN);

  logic [VLW-1:0]       w_vl_eff;
  logic [VLEN-1:0]      w_en;
  logic [VLEN*ELEN-1:0] w_data;
  logic                 w_push;
  logic                 w_pop;

  logic [VLEN*ELEN-1:0] r_data [2];
  logic [VLEN-1:0]      r_en   [2];
  logic [4:0]           r_vd   [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;

  assign w_vl_eff = (vl > VLEN_W) ? VLEN_W : vl;

  always_comb begin
    w_en   = '0;
    w_data = '0;
    for (int i = 0; i < VLEN; i++) begin
      w_en[i] = (VLW'(i) < w_vl_eff) && (vm || vmask[i]);
      w_data[i*ELEN +: ELEN] = w_en[i] ? aluout[i*ELEN +: ELEN] : vd_old[i*ELEN +: ELEN];
    end
  end

  assign in_ready  = !reset && (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  // Payload storage carries no reset; outputs are gated by count instead.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= w_data;
      r_en[r_wr_ptr]   <= w_en;
      r_vd[r_wr_ptr]   <= vd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign wdata    = out_valid ? r_data[r_rd_ptr] : '0;
  assign wen_mask = out_valid ? r_en[r_rd_ptr]   : '0;
  assign wvd      = out_valid ? r_vd[r_rd_ptr]   : '0;

endmodule

// File: tb/tb_vec_wb_stage.sv
// Directed bench for vec_wb_stage: merge rules, vl clamp, FIFO ordering,
// backpressure, flush and asynchronous reset.
module tb_vec_wb_stage;

  localparam int VLEN = 64;
  localparam int ELEN = 32;
  localparam int VLW  = 7;
  localparam int W    = VLEN * ELEN;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   aluout = '0;
  logic [W-1:0]   vd_old = '0;
  logic [VLEN-1:0] vmask = '0;
  logic           vm = 1'b1;
  logic [VLW-1:0] vl = '0;
  logic [4:0]     vd = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   wdata;
  logic [4:0]     wvd;
  logic [VLEN-1:0] wen_mask;

  int checks   = 0;
  int failures = 0;

  vec_wb_stage #(.VLEN(VLEN), .ELEN(ELEN), .VLW(VLW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluout(aluout), .vd_old(vd_old), .vmask(vmask), .vm(vm), .vl(vl), .vd(vd),
    .out_valid(out_valid), .out_ready(out_ready),
    .wdata(wdata), .wvd(wvd), .wen_mask(wen_mask)
  );

  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] fill(input logic [31:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < VLEN; i++) r[i*ELEN +: ELEN] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] ramp(input logic [31:0] base);
    logic [W-1:0] r;
    for (int i = 0; i < VLEN; i++) r[i*ELEN +: ELEN] = base + 32'(i);
    return r;
  endfunction

  function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < VLEN; i++)
      if (a[i*ELEN +: ELEN] !== b[i*ELEN +: ELEN]) return i;
    return 0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int k;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || wvd !== 5'd0 || wen_mask !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b ready=%b wvd=%0d mask=%h exp 0 0 0 0",
               out_valid, in_ready, wvd, wen_mask);
    end
    checks++;
    if (wdata !== '0) begin
      failures++; k = first_diff(wdata, '0);
      $display("FAIL reset_wdata: elem %0d got %h exp 0", k, wdata[k*ELEN +: ELEN]);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ready=%b valid=%b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_unmasked();
    logic [W-1:0] exp_d;
    int k;
    exp_d = ramp(32'd0);
    vm = 1'b1; vl = 7'd64; aluout = ramp(32'd0); vd_old = fill(32'hFFFF_FFFF);
    vd = 5'd3; out_ready = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || wvd !== 5'd3 || wen_mask !== {VLEN{1'b1}}) begin
      failures++;
      $display("FAIL unmasked_head: got valid=%b wvd=%0d mask=%h exp 1 3 ffffffffffffffff",
               out_valid, wvd, wen_mask);
    end
    checks++;
    if (wdata !== exp_d) begin
      failures++; k = first_diff(wdata, exp_d);
      $display("FAIL unmasked_wdata: elem %0d got %h exp %h", k, wdata[k*ELEN +: ELEN],
               exp_d[k*ELEN +: ELEN]);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL unmasked_drain: got valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_tail_mask();
    logic [VLEN-1:0] exp_m;
    logic [W-1:0]    exp_d;
    int k;
    exp_m = 64'h0000_0000_0000_0155;  // even elements 0..8
    for (int i = 0; i < VLEN; i++)
      exp_d[i*ELEN +: ELEN] = exp_m[i] ? 32'hA : 32'hB;
    vm = 1'b0; vl = 7'd10; vmask = 64'h5555_5555_5555_5555;
    aluout = fill(32'hA); vd_old = fill(32'hB); vd = 5'd4;
    out_ready = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || wvd !== 5'd4 || wen_mask !== exp_m) begin
      failures++;
      $display("FAIL tail_head: got valid=%b wvd=%0d mask=%h exp 1 4 %h",
               out_valid, wvd, wen_mask, exp_m);
    end
    checks++;
    if (wdata !== exp_d) begin
      failures++; k = first_diff(wdata, exp_d);
      $display("FAIL tail_wdata: elem %0d got %h exp %h", k, wdata[k*ELEN +: ELEN],
               exp_d[k*ELEN +: ELEN]);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL tail_drain: got valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_vl_clamp();
    logic [W-1:0] exp_d;
    int k;
    vm = 1'b1; vmask = '0; out_ready = 1'b1; in_valid = 1'b1;
    vl = 7'd127; aluout = ramp(32'd100); vd_old = fill(32'hDEAD_BEEF); vd = 5'd9;
    step();
    exp_d = ramp(32'd100);
    checks++;
    if (wvd !== 5'd9 || wen_mask !== {VLEN{1'b1}} || wdata !== exp_d) begin
      failures++; k = first_diff(wdata, exp_d);
      $display("FAIL vl127: got wvd=%0d mask=%h elem%0d=%h exp 9 all-ones %h",
               wvd, wen_mask, k, wdata[k*ELEN +: ELEN], exp_d[k*ELEN +: ELEN]);
    end
    // Push of vl=0 coincides with pop of the vl=127 entry.
    vl = 7'd0; aluout = ramp(32'd200); vd_old = fill(32'h1234_5678); vd = 5'd10;
    step();
    exp_d = fill(32'h1234_5678);
    checks++;
    if (out_valid !== 1'b1 || wvd !== 5'd10 || wen_mask !== '0 || wdata !== exp_d) begin
      failures++; k = first_diff(wdata, exp_d);
      $display("FAIL vl0: got valid=%b wvd=%0d mask=%h elem%0d=%h exp 1 10 0 %h",
               out_valid, wvd, wen_mask, k, wdata[k*ELEN +: ELEN], exp_d[k*ELEN +: ELEN]);
    end
    vl = 7'd63; aluout = ramp(32'd300); vd_old = fill(32'hC0C0_C0C0); vd = 5'd11;
    step();
    in_valid = 1'b0;
    exp_d = ramp(32'd300);
    exp_d[63*ELEN +: ELEN] = 32'hC0C0_C0C0;
    checks++;
    if (wvd !== 5'd11 || wen_mask !== 64'h7FFF_FFFF_FFFF_FFFF || wdata !== exp_d) begin
      failures++; k = first_diff(wdata, exp_d);
      $display("FAIL vl63: got wvd=%0d mask=%h elem%0d=%h exp 11 7fffffffffffffff %h",
               wvd, wen_mask, k, wdata[k*ELEN +: ELEN], exp_d[k*ELEN +: ELEN]);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL vl_drain: got valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    vm = 1'b1; vl = 7'd64; vd_old = '0; out_ready = 1'b0; in_valid = 1'b1;
    vd = 5'd1; aluout = fill(32'h1111_1111);
    step();
    vd = 5'd2; aluout = fill(32'h2222_2222);
    checks++;
    if (in_ready !== 1'b1 || wvd !== 5'd1) begin
      failures++;
      $display("FAIL bp_one: got ready=%b wvd=%0d exp 1 1", in_ready, wvd);
    end
    step();
    vd = 5'd3; aluout = fill(32'h3333_3333);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: got ready=%b exp 0", in_ready);
    end
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || wvd !== 5'd1 || wdata !== fill(32'h1111_1111) || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall: got valid=%b wvd=%0d elem0=%h ready=%b exp 1 1 11111111 0",
               out_valid, wvd, wdata[ELEN-1:0], in_ready);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full_pop: got ready=%b exp 0", in_ready);
    end
    step();
    checks++;
    if (wvd !== 5'd2 || wdata !== fill(32'h2222_2222) || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_second: got wvd=%0d elem0=%h ready=%b exp 2 22222222 1",
               wvd, wdata[ELEN-1:0], in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || wvd !== 5'd3 || wdata !== fill(32'h3333_3333)) begin
      failures++;
      $display("FAIL bp_third: got valid=%b wvd=%0d elem0=%h exp 1 3 33333333",
               out_valid, wvd, wdata[ELEN-1:0]);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || wdata !== '0) begin
      failures++;
      $display("FAIL bp_drain: got valid=%b elem0=%h exp 0 0", out_valid, wdata[ELEN-1:0]);
    end
  endtask

  task automatic test_flush();
    vm = 1'b1; vl = 7'd64; out_ready = 1'b0; in_valid = 1'b1;
    vd = 5'd7; aluout = fill(32'h7);
    step();
    vd = 5'd8; aluout = fill(32'h8);
    step();
    vd = 5'd9;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || wen_mask !== '0) begin
      failures++;
      $display("FAIL flush_full: got valid=%b ready=%b mask=%h exp 0 1 0", out_valid, in_ready, wen_mask);
    end
    in_valid = 1'b1; vd = 5'd12;
    step();
    vd = 5'd13; flush = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_ready: got ready=%b exp 1", in_ready);
    end
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_drop: got valid=%b wvd=%0d exp 0", out_valid, wvd);
    end
  endtask

  task automatic test_async_reset();
    vm = 1'b1; vl = 7'd64; out_ready = 1'b0; in_valid = 1'b1;
    vd = 5'd4; aluout = fill(32'h4);
    step();
    vd = 5'd5; aluout = fill(32'h5);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || wvd !== 5'd4) begin
      failures++;
      $display("FAIL areset_pre: got valid=%b wvd=%0d exp 1 4", out_valid, wvd);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || wen_mask !== '0 || wvd !== 5'd0 || in_ready !== 1'b0 || wdata !== '0) begin
      failures++;
      $display("FAIL areset_now: got valid=%b mask=%h wvd=%0d ready=%b exp 0 0 0 0",
               out_valid, wen_mask, wvd, in_ready);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL areset_after: got valid=%b ready=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_unmasked();
    test_tail_mask();
    test_vl_clamp();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
